multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle RV32I datapath, replacing the single-cycle main-decoder control path.
- Drives PC/IR write enables, memory strobes, ALU operand/result muxes and ALUOp (to the existing ALU decoder) over 3-5 cycles per instruction.
- Supports lw, sw, R-type, I-type ALU, beq and jal against one shared instruction/data memory with a ready handshake.
- Flags illegal opcodes and counts retired instructions.

Parameters:
INSTRET_W, 32, width of retired-instruction counter
TRAP_ON_ILLEGAL, 1, 1 = illegal opcode parks FSM in TRAP; 0 = treated as NOP and retired

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
op  input  7  instr[6:0] from IR
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  PC load enable
adr_src  output  1  memory address: 0 = PC, 1 = Result
mem_write  output  1  memory write strobe
ir_write  output  1  IR and OldPC load enable
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  00 PC, 01 OldPC, 10 reg A
alu_src_b  output  2  00 reg B, 01 ImmExt, 10 constant 4
imm_src  output  2  00 I, 01 S, 10 B, 11 J
alu_op  output  2  00 add, 01 sub, 10 funct-decoded
reg_write  output  1  register file write enable
illegal  output  1  sticky illegal-opcode flag
retire  output  1  one-cycle pulse on last cycle of each instruction
instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Moore FSM, registered state. Outputs are decoded combinationally from state (plus mem_ready and zero where noted). Unlisted outputs are 0 or 00.
- Reset asserted: state = FETCH, instret = 0, illegal = 0. pc_write, ir_write, mem_write, reg_write and retire are forced to 0. Mux selects show their FETCH values.
- Reset asserted mid-instruction: abandons it immediately, with no partial register or memory write.
- FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: alu_src_a 01, alu_src_b 01, alu_op 00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> TRAP if TRAP_ON_ILLEGAL = 1, else FETCH with retire = 1
- MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00. Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: adr_src 1, result_src 00. Hold while mem_ready = 0; go to MEMWB when mem_ready = 1.
- MEMWB: result_src 01, reg_write 1, retire 1. Next state FETCH.
- MEMWRITE: adr_src 1, result_src 00, mem_write 1. mem_write stays high while waiting; hold until mem_ready = 1. On mem_ready: retire 1, next state FETCH.
- EXECR: alu_src_a 10, alu_src_b 00, alu_op 10. Next state ALUWB.
- EXECI: alu_src_a 10, alu_src_b 01, alu_op 10. Next state ALUWB.
- ALUWB: result_src 00, reg_write 1, retire 1. Next state FETCH.
- BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, pc_write = zero, retire 1. Next state FETCH.
- JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_write 1. Next state ALUWB, which writes PC+4 to rd.
- TRAP: all enables 0, illegal = 1. Remains in TRAP until reset.
- imm_src is combinational from op in every state:
  - lw / I-type -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - other -> 00 (never X)
- instret increments by 1 on every retire cycle and wraps modulo 2^INSTRET_W.
- Latency with mem_ready tied high:
  - lw 5 cycles
  - sw, R-type, I-type, jal 4 cycles
  - beq 3 cycles
  - Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- No output is ever X, including for unknown op values.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL
  - state enum
  - mux-select encodings: RES_*, SRCA_*, SRCB_*, IMM_*, ALUOP_*
- One sub-module, instr_dec: combinational op -> imm_src and legality.
- The FSM remains in multicycle_controller.

Test Plan:
- Reset low mid-MEMWRITE with mem_ready=0 -> mem_write drops to 0 asynchronously; after reset high, FETCH, instret = 0.
- mem_ready=1, op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 in cycle 5 only; retire once; instret 0 -> 1.
- op=0100011, mem_ready low 3 cycles in MEMWRITE -> mem_write high 4 consecutive cycles; single retire pulse.
- op=1100011 with zero=1 then zero=0 -> pc_write=1 in BEQ cycle, then 0; 3 cycles each; instret +2.
- op=1101111 -> pc_write in JAL, reg_write with result_src 00 in ALUWB; imm_src = 11 throughout.
- op=1111111, TRAP_ON_ILLEGAL=1 -> illegal=1 from cycle after DECODE and stays; no enables for 20 cycles. With TRAP_ON_ILLEGAL=0 -> back to FETCH, instret +1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, FSM states and mux encodings for the multicycle controller
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath control bundle
interface multicycle_controller_if #(parameter int INSTRET_W = 32);
  logic [6:0]           op;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic [1:0]           result_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           imm_src;
  logic [1:0]           alu_op;
  logic                 reg_write;
  logic                 illegal;
  logic                 retire;
  logic [INSTRET_W-1:0] instret;

  // Controller side: consumes IR opcode / flags, drives every control line
  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_op, reg_write, illegal, retire, instret
  );

  // Datapath side
  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_op, reg_write, illegal, retire, instret
  );
endinterface

// File: rtl/multicycle_controller_instr_dec.sv
// rtl/multicycle_controller_instr_dec.sv - opcode to immediate format and legality
module instr_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o,
  output logic       legal_o
);

  // Unknown or X opcodes fall to the default arm, so imm_src is never X
  always_comb begin
    imm_src_o = IMM_I;
    legal_o   = 1'b0;
    case (op_i)
      OP_LOAD, OP_ITYPE, OP_RTYPE: legal_o = 1'b1;
      OP_STORE:  begin imm_src_o = IMM_S; legal_o = 1'b1; end
      OP_BRANCH: begin imm_src_o = IMM_B; legal_o = 1'b1; end
      OP_JAL:    begin imm_src_o = IMM_J; legal_o = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I sequencing FSM
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int INSTRET_W       = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  state_t               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q;
  logic                 illegal_q;
  logic                 illegal_set;
  logic                 legal;
  logic [1:0]           imm_src;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  instr_dec u_dec (
    .op_i      (bus.op),
    .imm_src_o (imm_src),
    .legal_o   (legal)
  );

  // State, retire counter and sticky illegal flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)      instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  // Next state and Moore outputs; enables are gated by reset so an abandoned instruction writes nothing
  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    retire      = 1'b0;
    illegal_set = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REGB;
    alu_op      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (!legal) begin
          illegal_set = 1'b1;
          if (TRAP_ON_ILLEGAL) begin
            state_d = S_TRAP;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else begin
          case (bus.op)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECR;
            OP_ITYPE:          state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BEQ;
            OP_JAL:            state_d = S_JAL;
            default:           state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = SRCA_REGA;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_REGA;
        alu_op    = ALUOP_SUB;
        pc_write  = bus.zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (!reset) begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      retire      = 1'b0;
      illegal_set = 1'b0;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.adr_src    = adr_src;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.imm_src    = imm_src;
  assign bus.alu_op     = alu_op;
  assign bus.reg_write  = reg_write;
  assign bus.retire     = retire;
  assign bus.illegal    = illegal_q;
  assign bus.instret    = instret_q;

endmodule
